// File: rtl/go_pkg.sv
// Shared types and constants for the Go board move link.
package go_pkg;

    localparam logic [7:0] PASS_MOVE         = 8'hFF;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } move_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    // Third packet byte: lets the receiver reject a corrupted move.
    function automatic logic [7:0] move_check(input logic [7:0] sync, input logic [7:0] mv);
        return sync ^ mv;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser with a registered line output; a start request in the last
// stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
    import go_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 564
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       line,
    output logic       byte_done
);

    localparam int unsigned CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    tx_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            line_q;
    logic            bit_end;

    assign bit_end   = (cnt_q == CntMax);
    assign byte_done = (state_q == STOP) && bit_end;
    assign line      = line_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            line_q    <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state_q   <= START;
                        shift_q   <= data;
                        bit_idx_q <= '0;
                        line_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                        line_q  <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            line_q  <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            line_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (start) begin
                            state_q   <= START;
                            shift_q   <= data;
                            bit_idx_q <= '0;
                            line_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    line_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/move_uart_tx.sv
// Sends a locally played move to the opponent board as a 3-byte UART packet:
// SYNC, MOVE, SYNC^MOVE.
module move_uart_tx
    import go_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 564,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tx_ready,
    input  logic [7:0] move,
    output logic       tx_out,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    move_t      mv_q;
    logic [1:0] byte_idx_q;
    logic       busy_q;
    logic       done_q;
    logic       overrun_q;

    logic       accept;
    logic       next_byte;
    logic       byte_start;
    logic       byte_done;
    logic [7:0] byte_data;

    always_comb begin
        accept     = tx_ready && !busy_q;
        next_byte  = busy_q && byte_done && (byte_idx_q < 2'd2);
        byte_start = accept || next_byte;
        // On accept the serialiser takes SYNC directly so the start bit needs no extra cycle.
        byte_data  = SYNC_BYTE;
        if (!accept) begin
            if (byte_idx_q == 2'd0) begin
                byte_data = mv_q;
            end else if (byte_idx_q == 2'd1) begin
                byte_data = move_check(SYNC_BYTE, mv_q);
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk_in   (clk_in),
        .reset    (reset),
        .start    (byte_start),
        .data     (byte_data),
        .line     (tx_out),
        .byte_done(byte_done)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mv_q       <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tx_ready && busy_q) begin
                overrun_q <= 1'b1;
            end
            if (accept) begin
                mv_q       <= move;
                busy_q     <= 1'b1;
                byte_idx_q <= '0;
            end else if (busy_q && byte_done) begin
                // Index 3 cannot occur; treating it like the last byte returns us to idle.
                if (byte_idx_q >= 2'd2) begin
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    byte_idx_q <= '0;
                end else begin
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule
